// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helper for the flexible-depth synchronous FIFO.
package sync_fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH    = 8;
   localparam int unsigned DEF_FIFO_DEPTH    = 12;
   localparam int unsigned DEF_AEMPTY_THRESH = 2;
   localparam int unsigned DEF_FWFT          = 0;

   // Bits needed to hold an occupancy of 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: registered write, asynchronous read, contents never reset.
module fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEF_FIFO_DEPTH,
   parameter int unsigned AW         = 4
)(
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO of arbitrary depth with registered count/flags, sticky
// error flags and a selectable standard or first-word-fall-through read port.
module sync_fifo_flex
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
   parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
   parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH,
   parameter int unsigned FWFT          = DEF_FWFT
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [DATA_WIDTH-1:0]            data_in,
   input  logic                             rd_en,
   input  logic                             clr_err,
   output logic [DATA_WIDTH-1:0]            data_out,
   output logic                             data_valid,
   output logic                             full,
   output logic                             empty,
   output logic                             almost_full,
   output logic                             almost_empty,
   output logic [cnt_width(FIFO_DEPTH)-1:0] count,
   output logic                             overflow,
   output logic                             underflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = cnt_width(FIFO_DEPTH);

   if (!(FIFO_DEPTH >= 2 && DATA_WIDTH >= 1 && AEMPTY_THRESH >= 1 &&
         AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= FIFO_DEPTH)) begin : g_bad_params
      $error("sync_fifo_flex: illegal parameter combination");
   end

   logic [AW-1:0]         wr_idx_q, wr_idx_d;
   logic [AW-1:0]         rd_idx_q, rd_idx_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] rdata;

   // Explicit wrap so non-power-of-two depths never touch an unused slot.
   function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
      return (idx == AW'(FIFO_DEPTH - 1)) ? '0 : idx + 1'b1;
   endfunction

   assign full         = (count_q == CW'(FIFO_DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AFULL_THRESH));
   assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   always_comb begin
      wr_acc   = wr_en && !full;
      rd_acc   = rd_en && !empty;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;

      if (wr_acc) wr_idx_d = next_idx(wr_idx_q);
      if (rd_acc) rd_idx_d = next_idx(rd_idx_q);

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A new error in the same cycle as clr_err must survive the clear.
      if (clr_err)         ovf_d = 1'b0;
      if (wr_en && full)   ovf_d = 1'b1;
      if (clr_err)         unf_d = 1'b0;
      if (rd_en && empty)  unf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (wr_acc),
      .waddr_i (wr_idx_q),
      .wdata_i (data_in),
      .raddr_i (rd_idx_q),
      .rdata_o (rdata)
   );

   if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dv_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
         end else begin
            dv_q <= rd_acc;
            if (rd_acc) dout_q <= rdata;
         end
      end

      assign data_out   = dout_q;
      assign data_valid = dv_q;
   end else begin : g_fwft
      // Head slot is read combinationally; a write into empty shows once count leaves 0.
      assign data_out   = empty ? '0 : rdata;
      assign data_valid = !empty;
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a standard-read and an FWFT instance with identical directed stimulus
// and checks both against a queue-based model every cycle.
module tb_sync_fifo_flex;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic       clr_err = 1'b0;
   logic [4:0] data_in = '0;

   logic [4:0] s_dout, f_dout;
   logic       s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [3:0] s_count, f_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sync_fifo_flex #(.DATA_WIDTH(5), .FIFO_DEPTH(12), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .clr_err(clr_err), .data_out(s_dout), .data_valid(s_dv), .full(s_full),
      .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
      .overflow(s_ovf), .underflow(s_unf));

   sync_fifo_flex #(.DATA_WIDTH(5), .FIFO_DEPTH(12), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .clr_err(clr_err), .data_out(f_dout), .data_valid(f_dv), .full(f_full),
      .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ovf), .underflow(f_unf));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: contents as a queue, occupancy is its size, errors from the interface rules.
   logic [4:0] mq[$];
   bit         m_ovf = 0, m_unf = 0, m_v0 = 0, started = 0;
   logic [4:0] m_d0 = '0;
   int         m_n;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_ovf = 0; m_unf = 0; m_v0 = 0; m_d0 = '0;
         started = 1;
      end else begin
         m_n = mq.size();
         if (wr_en && m_n == 12) m_ovf = 1; else if (clr_err) m_ovf = 0;
         if (rd_en && m_n == 0)  m_unf = 1; else if (clr_err) m_unf = 0;
         m_v0 = rd_en && m_n > 0;
         if (m_v0) m_d0 = mq.pop_front();
         if (wr_en && m_n < 12) mq.push_back(data_in);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("count_std", s_count, mq.size());
         chk("count_fwft", f_count, mq.size());
         chk("full_std", s_full, mq.size() == 12);
         chk("full_fwft", f_full, mq.size() == 12);
         chk("empty_std", s_empty, mq.size() == 0);
         chk("empty_fwft", f_empty, mq.size() == 0);
         chk("afull_std", s_af, mq.size() >= 10);
         chk("afull_fwft", f_af, mq.size() >= 10);
         chk("aempty_std", s_ae, mq.size() <= 2);
         chk("aempty_fwft", f_ae, mq.size() <= 2);
         chk("ovf_std", s_ovf, m_ovf);
         chk("ovf_fwft", f_ovf, m_ovf);
         chk("unf_std", s_unf, m_unf);
         chk("unf_fwft", f_unf, m_unf);
         chk("dv_std", s_dv, m_v0);
         chk("dout_std", s_dout, m_d0);
         chk("dv_fwft", f_dv, mq.size() != 0);
         if (mq.size() != 0) chk("dout_fwft", f_dout, mq[0]);
      end
   end

   // Inputs change just after a falling edge; return at the next falling edge.
   task automatic step(input logic w, input logic [4:0] d, input logic r, input logic c);
      wr_en = w; data_in = d; rd_en = r; clr_err = c;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      repeat (2) step(0, '0, 0, 0);
      rst = 1'b0;
      chk("lit_rst_empty", s_empty, 1);
      chk("lit_rst_aempty", s_ae, 1);
      chk("lit_rst_full", s_full, 0);
      chk("lit_rst_afull", s_af, 0);
      chk("lit_rst_dout", s_dout, 0);
      chk("lit_rst_dv", s_dv, 0);

      for (int i = 1; i <= 12; i++) begin
         step(1, 5'(i), 0, 0);
         if (i == 9)  chk("lit_afull_at9", s_af, 0);
         if (i == 10) chk("lit_afull_at10", s_af, 1);
         if (i == 11) chk("lit_full_at11", s_full, 0);
      end
      chk("lit_full_at12", s_full, 1);
      chk("lit_count12", s_count, 12);
      step(1, 5'd13, 0, 0);
      chk("lit_ovf_set", s_ovf, 1);
      chk("lit_count_stays12", s_count, 12);
      step(0, '0, 0, 1);
      chk("lit_ovf_clr", s_ovf, 0);

      for (int i = 1; i <= 12; i++) begin
         step(0, '0, 1, 0);
         chk("lit_rd_data", s_dout, i);
         chk("lit_rd_valid", s_dv, 1);
      end
      chk("lit_empty_after_drain", s_empty, 1);
      step(0, '0, 1, 0);
      chk("lit_unf_set", s_unf, 1);
      chk("lit_no_valid_on_empty", s_dv, 0);
      step(0, '0, 0, 1);

      for (int i = 0; i < 8; i++)  step(1, 5'(i + 16), 0, 0);
      for (int i = 0; i < 8; i++)  step(0, '0, 1, 0);
      chk("lit_last_of_8", s_dout, 5'd23);
      for (int i = 0; i < 10; i++) step(1, 5'(i + 2), 0, 0);
      for (int i = 0; i < 10; i++) step(0, '0, 1, 0);
      chk("lit_last_of_10", s_dout, 5'd11);
      chk("lit_count_end0", s_count, 0);

      for (int i = 0; i < 12; i++) step(1, 5'(i + 7), 0, 0);
      step(1, 5'd31, 1, 0);
      chk("lit_full_both_head", s_dout, 5'd7);
      chk("lit_full_both_ovf", s_ovf, 1);
      for (int i = 0; i < 11; i++) step(0, '0, 1, 0);
      step(1, 5'd9, 1, 0);
      chk("lit_empty_both_count", s_count, 1);
      chk("lit_empty_both_unf", s_unf, 1);
      chk("lit_empty_both_nobypass", s_dv, 0);
      step(0, '0, 0, 1);
      chk("lit_clr_ovf", s_ovf, 0);
      chk("lit_clr_unf", s_unf, 0);
      step(0, '0, 1, 0);
      chk("lit_read9", s_dout, 5'd9);
      step(0, '0, 1, 1);
      chk("lit_set_beats_clr", s_unf, 1);
      step(0, '0, 0, 1);

      step(1, 5'h15, 0, 0);
      chk("lit_fwft_dout", f_dout, 5'h15);
      chk("lit_fwft_dv", f_dv, 1);
      step(0, '0, 1, 0);
      chk("lit_fwft_empty", f_empty, 1);
      chk("lit_fwft_dv_low", f_dv, 0);

      for (int i = 0; i < 12; i++) step(1, 5'(i + 20), 0, 0);
      step(1, 5'd1, 0, 0);
      for (int i = 0; i < 7; i++) step(0, '0, 1, 0);
      chk("lit_pre_rst_count5", s_count, 5);
      chk("lit_pre_rst_ovf", s_ovf, 1);
      rst = 1'b1;
      step(1, 5'd30, 1, 1);
      rst = 1'b0;
      chk("lit_rst_mid_count", s_count, 0);
      chk("lit_rst_mid_empty", s_empty, 1);
      chk("lit_rst_mid_ovf", s_ovf, 0);
      chk("lit_rst_mid_dout", s_dout, 0);
      step(1, 5'h1A, 0, 0);
      chk("lit_post_rst_fwft", f_dout, 5'h1A);
      step(0, '0, 1, 0);
      chk("lit_post_rst_read", s_dout, 5'h1A);
      step(0, '0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
